// File: rtl/reg_cmd_pkg.sv
// Shared types and constants for the register command controller.
// No logic, so no latency.
// No handshake, so no backpressure.
package reg_cmd_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_CMD     = 2'b01;
    localparam logic [1:0] ERR_ADDR    = 2'b10;
    localparam logic [1:0] ERR_DROP    = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

    // The controller reports busy whenever it cannot accept a frame byte.
    function automatic logic is_busy(input state_t s);
        return !(s inside {IDLE, WR_ADDR, WR_DATA, RD_ADDR});
    endfunction

    // An address byte is legal only if it names an existing register.
    function automatic logic addr_ok(input logic [7:0] b);
        return b < 8'(DEPTH);
    endfunction

endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// Bundle of the UART RX, register file and TX FIFO signals seen by the controller.
// Wires only, so no latency.
// FIFO_Full is the only backpressure input; RX bytes cannot be stalled.
interface reg_cmd_ctrl_if;
    import reg_cmd_pkg::*;

    logic [7:0]        RX_Data;
    logic              RX_Valid;
    logic              WrEn;
    logic              RdEn;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              RdData_Valid;
    logic              FIFO_Full;
    logic              TX_WrEn;
    logic [7:0]        TX_Data;
    logic              Busy;
    logic              Err_Pulse;
    logic [1:0]        Err_Code;

    // Controller side: it initiates register accesses and TX pushes.
    modport master (
        input  RX_Data, RX_Valid, RdData, RdData_Valid, FIFO_Full,
        output WrEn, RdEn, Address, WrData, TX_WrEn, TX_Data,
               Busy, Err_Pulse, Err_Code
    );

    // Environment side: UART RX, register file and TX FIFO.
    modport slave (
        output RX_Data, RX_Valid, RdData, RdData_Valid, FIFO_Full,
        input  WrEn, RdEn, Address, WrData, TX_WrEn, TX_Data,
               Busy, Err_Pulse, Err_Code
    );

endinterface

// File: rtl/reg_cmd_timeout.sv
// Inter-byte timer: counts cycles while a frame is half received, cleared by every byte.
// expired is combinational from the count, asserting when count reaches TIMEOUT-1.
// No backpressure; run/clr are sampled every cycle.
module reg_cmd_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = run && !clr && (cnt_q == CW'(TIMEOUT - 1));

    // Next count: restart on any byte, outside counting states, or on expiry.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || clr || expired) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Decodes AA/BB frames from UART RX into register writes/reads; read bytes go to the TX FIFO.
// Latency: WrEn/RdEn one cycle after the last frame byte; TX_WrEn one cycle after RdData_Valid.
// Backpressure: FIFO_Full holds the TX push; bytes arriving while busy are dropped with an error.
// Optional REG_CMD_TIMEOUT_EN abandons a half-received frame after TIMEOUT idle cycles.
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic          CLK,
    input  logic          RST,
    reg_cmd_ctrl_if.master bus
);

    state_t            state_q,     state_d;
    logic              wr_en_q,     wr_en_d;
    logic              rd_en_q,     rd_en_d;
    logic              tx_wr_en_q,  tx_wr_en_d;
    logic              busy_q,      busy_d;
    logic              err_pulse_q, err_pulse_d;
    logic [1:0]        err_code_q,  err_code_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic [7:0]        tx_data_q,   tx_data_d;
    logic              tmo_expired;

`ifdef REG_CMD_TIMEOUT_EN
    logic tmo_run;
    assign tmo_run = state_q inside {WR_ADDR, WR_DATA, RD_ADDR};

    reg_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .run     (tmo_run),
        .clr     (bus.RX_Valid),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo_expired    = 1'b0;
`endif

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d     = state_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        tx_wr_en_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_data_d   = tx_data_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_Valid) begin
                    if (bus.RX_Data == WR_CMD) begin
                        state_d = WR_ADDR;
                    end else if (bus.RX_Data == RD_CMD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CMD;
                    end
                end
            end

            WR_ADDR, RD_ADDR: begin
                if (bus.RX_Valid) begin
                    if (!addr_ok(bus.RX_Data)) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_ADDR;
                        state_d     = IDLE;
                    end else begin
                        addr_d = bus.RX_Data[ADDR_W-1:0];
                        if (state_q == WR_ADDR) begin
                            state_d = WR_DATA;
                        end else begin
                            state_d = RD_EXEC;
                            rd_en_d = 1'b1;
                        end
                    end
                end else if (tmo_expired) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = IDLE;
                end
            end

            WR_DATA: begin
                if (bus.RX_Valid) begin
                    wr_data_d = bus.RX_Data[DATA_W-1:0];
                    wr_en_d   = 1'b1;
                    state_d   = WR_EXEC;
                end else if (tmo_expired) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = IDLE;
                end
            end

            WR_EXEC: begin
                state_d = IDLE;
            end

            RD_EXEC: begin
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                if (bus.RdData_Valid) begin
                    tx_data_d  = 8'(bus.RdData);
                    tx_wr_en_d = !bus.FIFO_Full;
                    state_d    = TX_SEND;
                end
            end

            TX_SEND: begin
                // The push cycle is the one where tx_wr_en_q is already high.
                if (tx_wr_en_q) begin
                    state_d = IDLE;
                end else begin
                    tx_wr_en_d = !bus.FIFO_Full;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Any byte landing while a bus access is in flight is lost.
        if (bus.RX_Valid && is_busy(state_q)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_DROP;
        end

        busy_d = is_busy(state_d);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            tx_wr_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            tx_wr_en_q  <= tx_wr_en_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.TX_WrEn   = tx_wr_en_q;
    assign bus.Busy      = busy_q;
    assign bus.Err_Pulse = err_pulse_q;
    assign bus.Err_Code  = err_code_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wr_data_q;
    assign bus.TX_Data   = tx_data_q;

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Command controller that drives the register file from the byte stream produced by the UART receiver. It decodes write (0xAA) and read (0xBB) frames and issues single-cycle WrEn/RdEn accesses. It captures RdData on RdData_Valid and pushes the read byte into the TX FIFO. It sits between UART RX and the register file in the CLK domain, acting as the initiator to the register file's responder.

## Interface
- Data, 8, register data width.
- Depth, 8, number of registers; valid addresses are 0..Depth-1.
- Addr, 3, address width (log2 Depth).
- WR_CMD, 8'hAA, write command byte.
- RD_CMD, 8'hBB, read command byte.
- TIMEOUT, 1024, inter-byte timeout in CLK cycles; used only with REG_CMD_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_Data  in  8  received byte; qualified by RX_Valid.
- RX_Valid  in  1  one-cycle pulse per received byte.
- WrEn  out  1  register file write strobe.
- RdEn  out  1  register file read strobe.
- Address  out  Addr  register address.
- WrData  out  Data  register write data.
- RdData  in  Data  register file read data.
- RdData_Valid  in  1  register file read-data qualifier.
- FIFO_Full  in  1  TX FIFO full.
- TX_WrEn  out  1  TX FIFO push, one cycle.
- TX_Data  out  8  byte pushed to the TX FIFO.
- Busy  out  1  high in every state except IDLE, WR_ADDR, WR_DATA and RD_ADDR.
- Err_Pulse  out  1  one-cycle error strobe.
- Err_Code  out  2  error cause, valid with Err_Pulse: 01 unknown command, 10 address out of range, 11 byte dropped while busy, 00 timeout.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- Transitions out of IDLE, on RX_Valid:
  - RX_Data==WR_CMD -> WR_ADDR.
  - RX_Data==RD_CMD -> RD_ADDR.
  - Any other byte -> Err 01, stay in IDLE.
- Address byte handling (WR_ADDR/RD_ADDR), on RX_Valid:
  - If RX_Data >= Depth -> Err 10, frame discarded, return to IDLE.
  - Otherwise Address <= RX_Data[Addr-1:0]; WR_ADDR -> WR_DATA, RD_ADDR -> RD_EXEC.
- WR_DATA: on RX_Valid, WrData <= RX_Data, go to WR_EXEC.
- WR_EXEC: WrEn=1 for exactly one cycle, then IDLE.
- RD_EXEC: RdEn=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT: on RdData_Valid, TX_Data <= RdData (zero-extended to 8 bits), go to TX_SEND.
- TX_SEND: while FIFO_Full, hold state. When !FIFO_Full, TX_WrEn=1 for one cycle, then IDLE.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their values until overwritten by a later frame.
- RX_Valid in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: byte dropped, Err 11, state unchanged.
- All outputs are registered.

## Timing
- Reset values: state IDLE; WrEn, RdEn, TX_WrEn, Err_Pulse, Busy = 0; Address, WrData, TX_Data, Err_Code = 0.
- Reset asserted mid-frame aborts immediately. No strobe may be issued after reset deasserts until a new frame arrives.
- Write latency: data byte RX_Valid sampled at edge k -> WrEn high during cycle k+1.
- Read latency: address byte sampled at edge k -> RdEn high during cycle k+1.
  - The register file asserts RdData_Valid in cycle k+2.
  - TX_WrEn is high in cycle k+3 when FIFO_Full is low.
- TX_WrEn asserts in the first cycle after TX_SEND entry in which FIFO_Full is low. TX_Data is stable from TX_SEND entry until the push.
- Err_Pulse is high for exactly one cycle, in the cycle after the offending RX_Valid.

## Configuration
- REG_CMD_TIMEOUT_EN defined:
  - A counter runs in WR_ADDR, WR_DATA and RD_ADDR, clearing on each RX_Valid.
  - On reaching TIMEOUT-1 with no byte received -> Err 00, return to IDLE, no bus access.
- Undefined: no timer; the controller waits indefinitely for the next byte. Err_Code 00 is never produced.

## Structure
- Package reg_cmd_pkg holds:
  - state encoding;
  - WR_CMD/RD_CMD default constants;
  - Err_Code constants (ERR_TIMEOUT, ERR_CMD, ERR_ADDR, ERR_DROP).
- Sub-module reg_cmd_timeout: the clearable inter-byte counter, instantiated only under REG_CMD_TIMEOUT_EN.
- The FSM lives in reg_cmd_ctrl.

## Test plan
- Write frame: RX bytes AA,05,3C -> one-cycle WrEn with Address=5, WrData=3C; no TX_WrEn, no error.
- Read frame after write: RX BB,05 with the register file returning 3C -> one RdEn pulse, then TX_WrEn with TX_Data=3C, 3 cycles after the address byte.
- Errors:
  - RX 55 -> Err 01.
  - RX BB,09 (Depth=8) -> Err 10, no RdEn.
  - Byte received during RD_WAIT -> Err 11, read completes normally.
- FIFO stall: FIFO_Full high for 10 cycles during TX_SEND -> TX_WrEn withheld, then a single push with TX_Data unchanged.
- Reset mid-frame: RST low after AA,02 -> outputs return to reset values; a following RD frame works normally.
- Timeout (macro on, TIMEOUT=16): AA then silence -> Err 00 after 16 cycles, return to IDLE; with the macro off, the controller stays in WR_ADDR.
